latency_timer: RTL



---
 rtl/latency_timer_pkg.sv | 7 +
 rtl/latency_timer_if.sv | 10 +
 rtl/latency_timer_edge_detect.sv | 23 ++
 rtl/latency_timer.sv | 68 ++++++
 4 files changed

// File: rtl/latency_timer_pkg.sv
// latency_timer_pkg: shared state encoding and result-word layout for latency_timer
package latency_timer_pkg;
    typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_t;
    localparam int DONE_BIT  = 31;
    localparam int OVF_BIT   = 30;
    localparam int CNT_W_MAX = 30;
endpackage

// File: rtl/latency_timer_if.sv
// latency_timer_if: start/stop levels in, packed PIO result word and busy out
interface latency_timer_if;
    import latency_timer_pkg::*;
    logic             start_in;
    logic             stop_in;
    logic [DONE_BIT:0] result;
    logic             busy;
    modport master (output start_in, stop_in, input result, busy);
    modport slave (input start_in, stop_in, output result, busy);
endinterface

// File: rtl/latency_timer_edge_detect.sv
// lt_edge_detect: rising-edge pulse, optional 2-flop synchronizer under LATENCY_TIMER_SYNC_EN
module lt_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic s;
    logic prev;
`ifdef LATENCY_TIMER_SYNC_EN
    logic [1:0] sync;
    // two-flop synchronizer; loads ones so a high input through reset gives no edge
    always_ff @(posedge clk)
        sync <= reset ? 2'b11 : {sync[0], d};
    assign s = sync[1];
`else
    assign s = d;
`endif
    // previous value; loads 1 in reset so a level held high is not an edge
    always_ff @(posedge clk)
        prev <= reset ? 1'b1 : s;
    assign rise = s & ~prev;
endmodule

// File: rtl/latency_timer.sv
// latency_timer: start-to-stop cycle counter packed for PIO in_port; LATENCY_TIMER_SYNC_EN adds input synchronizers
module latency_timer
    import latency_timer_pkg::*;
#(
    parameter int CNT_W = 30
) (
    input logic             clk,
    input logic             reset,
    latency_timer_if.slave  lt
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             start_rise;
    logic             stop_rise;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_nx;
    logic [31:0]      done_word;

    lt_edge_detect u_start (.clk(clk), .reset(reset), .d(lt.start_in), .rise(start_rise));
    lt_edge_detect u_stop  (.clk(clk), .reset(reset), .d(lt.stop_in),  .rise(stop_rise));

    assign cnt_max = &cnt;
    assign cnt_nx  = cnt_max ? cnt : cnt + CNT_W'(1);
    assign ovf_nx  = ovf | cnt_max;

    // the word latched on stop already includes the stop cycle itself
    always_comb begin
        done_word           = '0;
        done_word[DONE_BIT] = 1'b1;
        done_word[OVF_BIT]  = ovf_nx;
        done_word[CNT_W-1:0] = cnt_nx;
    end

    // measurement FSM with registered result and busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ovf       <= 1'b0;
            lt.result <= '0;
            lt.busy   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start_rise) begin
                    state     <= COUNTING;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    lt.result <= '0;
                    lt.busy   <= 1'b1;
                end
                COUNTING: if (stop_rise) begin
                    state     <= DONE;
                    lt.result <= done_word;
                    lt.busy   <= 1'b0;
                end else begin
                    cnt <= cnt_nx;
                    ovf <= ovf_nx;
                end
                default: begin
                    state   <= IDLE;
                    lt.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
